// File: rtl/bit_collector.sv
// ---------------------------------------------------------------------------
// bit_collector
//
// Serial-to-parallel pixel packer. It is the receive-side counterpart of the
// display word serializer. A 1-bit pixel stream is sampled once every mult+1
// enabled cycles. The samples are packed MSB-first into width-bit words.
// Completed words are held in a one-entry output slot. The framebuffer
// write-back logic drains that slot over a valid/ready handshake.
//
// Ports
//   clk       in   1      pixel clock, all state changes on the rising edge
//   rst_n     in   1      asynchronous active-low reset
//   clear     in   1      synchronous restart of word assembly, also clears
//                         overflow. Takes priority over enable.
//   enable    in   1      pixel strobe. When low, only the output handshake
//                         can change state.
//   din       in   1      serial pixel input
//   mult      in   4      pixel repeat count minus one
//   q         out  width  completed word; the first sampled pixel is in
//                         bit width-1
//   q_valid   out  1      q holds a word that has not been consumed yet
//   q_ready   in   1      consumer is ready to take q
//   overflow  out  1      sticky flag: a completed word was dropped
//
// Handshake: a word moves to the consumer on every rising edge where
// q_valid && q_ready is high. q_valid stays high, and q stays stable, until
// that edge. Acceptance does not depend on enable or clear. If a new word
// completes on the same edge that the old word is accepted, the slot is
// reloaded and q_valid stays high with no gap.
//
// Parameter width must lie in 2..16.
// ---------------------------------------------------------------------------
module bit_collector #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             din,
  input  logic [3:0]       mult,
  output logic [width-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overflow
);

  // The bit counter must be able to hold values 0..width-1.
  localparam int cw = $clog2(width + 1);
  localparam logic [cw-1:0] last_idx = cw'(width - 1);

  logic [3:0]       rep_cnt;
  logic [cw-1:0]    bit_cnt;
  // Only width-1 bits are kept. The final bit of a word comes straight from
  // din on the completing cycle.
  logic [width-2:0] shift;

  logic             sample;
  logic             complete;
  logic [width-1:0] word;
  logic             accept;

  // The >= compare matters when mult is lowered mid-group. The counter may
  // already be past the new limit. With >= it samples on the next enabled
  // cycle instead of counting all the way round to 16.
  assign sample   = enable && !clear && (rep_cnt >= mult);
  assign complete = sample && (bit_cnt == last_idx);
  assign word     = {shift, din};
  assign accept   = q_valid && q_ready;

  // Assembly side: repeat counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (clear) begin
      rep_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (enable) begin
      if (sample) begin
        rep_cnt <= '0;
        if (complete) begin
          // Restart right away so the next sample begins a new word.
          bit_cnt <= '0;
          shift   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shift   <= word[width-2:0];
        end
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  // Output slot and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      q_valid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (complete) begin
        if (!q_valid || accept) begin
          q       <= word;
          q_valid <= 1'b1;
        end else begin
          // The slot is full and not being drained, so the new word is lost.
          overflow <= 1'b1;
        end
      end else if (accept) begin
        q_valid <= 1'b0;
      end
      // A clear cycle never samples, so it never completes a word. Clearing
      // overflow here therefore cannot clash with the set above.
      if (clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_collector.sv
// ---------------------------------------------------------------------------
// tb_bit_collector
//
// Directed bench for bit_collector with width=16. The stimulus tasks push
// every word that should reach the consumer onto exp_q. A monitor on the
// falling edge pops and compares each word that the DUT hands over
// (q_valid && q_ready). Flag and timing checks are made inline against
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_bit_collector;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         enable;
  logic         din;
  logic [3:0]   mult;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         overflow;

  logic [W-1:0] exp_q[$];
  int           vectors;
  int           miscompares;

  bit_collector #(.width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .enable   (enable),
    .din      (din),
    .mult     (mult),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .overflow (overflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: runs on the falling edge, when the inputs are stable.
  always @(negedge clk) begin
    if (rst_n && q_valid && q_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", q, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (q !== e) begin
          miscompares++;
          $display("FAIL word: got %0h expected %0h at %0t", q, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge and are captured on the
  // next rising edge.
  task automatic send_bit(input logic b);
    enable = 1'b1;
    din    = b;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clear();
    clear  = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    clear  = 1'b0;
  endtask

  // Raise q_ready and wait, within a cycle budget, for every expected word.
  task automatic drain(input string name);
    int n;
    q_ready = 1'b1;
    enable  = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] w;
    logic         dropped;
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    clear   = 1'b0;
    enable  = 1'b0;
    din     = 1'b0;
    mult    = 4'd0;
    q_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", q, 0);
    chk("reset_q_valid", q_valid, 0);
    chk("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: mult=0, q_ready high, q_valid lasts exactly one cycle.
    q_ready = 1'b1;
    mult    = 4'd0;
    exp_q.push_back(16'hA0F1);
    send_word(16'hA0F1);
    enable = 1'b0;
    chk("t1_valid_rise", q_valid, 1);
    idle(1);
    chk("t1_valid_fall", q_valid, 0);
    drain("t1");

    // 2: mult=3, each bit held for a group of 4 cycles.
    pulse_clear();
    mult = 4'd3;
    exp_q.push_back(16'hB000);
    for (int g = 0; g < 16; g++) begin
      for (int c = 0; c < 4; c++) send_bit((g == 0) || (g == 2) || (g == 3));
      if (g == 14) chk("t2_not_yet", q_valid, 0);
    end
    enable = 1'b0;
    chk("t2_valid", q_valid, 1);
    drain("t2");

    // 3: consumer stalled, so the second word overflows.
    pulse_clear();
    mult    = 4'd0;
    q_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    chk("t3_valid_w1", q_valid, 1);
    chk("t3_no_ovf_w1", overflow, 0);
    send_word(16'h5678);
    enable = 1'b0;
    chk("t3_ovf", overflow, 1);
    chk("t3_q_held", q, 16'h1234);
    drain("t3");
    chk("t3_valid_drop", q_valid, 0);
    chk("t3_ovf_sticky", overflow, 1);
    pulse_clear();
    chk("t3_ovf_cleared", overflow, 0);

    // 4: q_ready pulsed exactly on the completion edge of word 2.
    q_ready = 1'b0;
    exp_q.push_back(16'hFFFF);
    send_word(16'hFFFF);
    exp_q.push_back(16'h0001);
    w = 16'h0001;
    dropped = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 0) q_ready = 1'b1;
      send_bit(w[i]);
      q_ready = 1'b0;
      if (!q_valid) dropped = 1'b1;
    end
    enable = 1'b0;
    chk("t4_valid_continuous", dropped, 0);
    chk("t4_no_ovf", overflow, 0);
    chk("t4_q_new", q, 16'h0001);
    drain("t4");

    // 5: clear after 7 bits (with enable high) discards the partial word.
    q_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    exp_q.push_back(16'hC3C3);
    send_word(16'hC3C3);
    drain("t5");

    // 6: asynchronous reset mid-word while the slot is full and overflowed.
    q_ready = 1'b0;
    send_word(16'h1111);
    send_word(16'h2222);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("t6_pre_ovf", overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_q", q, 0);
    chk("t6_async_valid", q_valid, 0);
    chk("t6_async_ovf", overflow, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    q_ready = 1'b1;
    exp_q.push_back(16'h9E37);
    send_word(16'h9E37);
    drain("t6");

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_collector.md
Name: bit_collector

Overview:
- Serial-to-parallel pixel packer; the receive-side counterpart of the display word serializer.
- Samples a 1-bit pixel stream at a programmable repeat rate and packs it MSB-first into width-bit words.
- Presents completed words on a valid/ready output for write-back into framebuffer RAM (screen capture, collision readback, test loopback).
- Holds one completed word while the next is being assembled.

Parameters:
- width, 16, bits per packed word; legal range 2..16.

Ports:
- clk  input  1  pixel clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous restart of word assembly; also clears overflow
- enable  input  1  pixel strobe; no state change when low, except output handshake
- din  input  1  serial pixel in
- mult  input  4  pixel repeat count less one; one sample per mult+1 enabled cycles
- q  output  width  completed word; first sampled pixel at bit width-1
- q_valid  output  1  q holds an unconsumed word
- q_ready  input  1  consumer accepts q when q_valid && q_ready at a clock edge
- overflow  output  1  sticky; a completed word was dropped

Behaviour:
- Reset (rst_n low, asynchronous):
  - q=0, q_valid=0, overflow=0.
  - Repeat counter=0, bit count=0, shift register=0.
- Repeat counter, 4 bits:
  - On an enable cycle, if counter >= mult: sample din and set counter=0.
  - Otherwise counter increments.
  - The >= compare makes a mid-group decrease of mult take effect on the next enable cycle, with no 16-cycle wrap.
- Sample, per accepted bit:
  - shift <= {shift[width-2:0], din}.
  - bit count increments.
- Word completion, on the sample that makes bit count reach width:
  - Completed word = {shift[width-2:0], din}.
  - Bit count and shift register reset to 0 in the same cycle.
  - No dead cycle: the next sample starts the next word.
- Output register:
  - Empty slot (q_valid=0), or being accepted the same edge (q_valid && q_ready): q <= completed word, q_valid <= 1.
  - Otherwise the slot is full and not accepted: completed word dropped, q unchanged, overflow <= 1.
  - No completion and q_valid && q_ready: q_valid <= 0; q keeps its old value.
  - Acceptance happens regardless of enable.
- Latency: q_valid rises on the edge following the clock that samples the last bit.
- clear, synchronous, highest priority over enable:
  - Repeat counter, bit count, shift register and overflow go to 0.
  - Any partial word is discarded.
  - q and q_valid are not affected; the handshake still completes the same cycle if q_ready is high.
  - clear && enable on the same cycle: no sample is taken.
- mult=0: every enabled cycle samples.
- Changing mult mid-word affects only the spacing of later samples; bits already collected are kept.
- Changing width is elaboration-only.
- Reset mid-word or mid-handshake aborts everything immediately; there is no recovery of a partial word.

Test Plan:
1. mult=0, enable held high, din=1010_0000_1111_0001 MSB-first, q_ready=1 → q=16'hA0F1; q_valid high for exactly one cycle, one clock after the 16th bit.
2. mult=3, enable high, din constant per 4-cycle group with pattern 1,0,1,1 then zeros → sample on the 4th cycle of each group; after 64 cycles q=16'hB000.
3. q_ready=0, mult=0, stream two full words 16'h1234, 16'h5678 → q=16'h1234 held, q_valid=1; overflow=1 after the 32nd bit. Then q_ready=1 → q_valid drops, overflow stays 1 until clear.
4. Back-to-back words with q_ready pulsed exactly on the completion edge of word 2 → q goes 16'hFFFF to 16'h0001 with q_valid continuously high, overflow=0.
5. After 7 bits, assert clear for one cycle (enable high), then stream 16'hC3C3 → q=16'hC3C3; no bits from the partial word leak in.
6. Drop rst_n mid-word while q_valid=1 → q=0, q_valid=0, overflow=0 immediately, without waiting for a clock edge. After release, a fresh 16-bit stream yields the correct word.
